// File: rtl/mac_array_sequencer.sv
// Control FSM for the 8-lane matrix-vector MAC array: fetches A rows and B over a
// stalling read port, unpacks bytes into the FIFOs, then streams them through the MACs.
module mac_array_sequencer #(
  parameter int DIM        = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic                      mem_read,
  input  logic                      mem_waitrequest,
  input  logic [DIM*DATA_WIDTH-1:0] mem_readdata,
  input  logic                      mem_readdatavalid,
  output logic [DIM-1:0]            fifo_a_wr,
  output logic                      fifo_b_wr,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                      fifo_rd_en,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic [2:0]                state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_REQ  = 3'd1;
  localparam logic [2:0] S_READ_WAIT = 3'd2;
  localparam logic [2:0] S_UNPACK    = 3'd3;
  localparam logic [2:0] S_COMPUTE   = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam int WORD_W = DIM * DATA_WIDTH;
  localparam int ROW_W  = $clog2(DIM + 1);
  localparam int CNT_W  = $clog2(DIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIM - 1);
  localparam logic [ROW_W-1:0] ROW_B    = ROW_W'(DIM);

  logic [2:0]            state, state_n;
  logic [ROW_W-1:0]      row, row_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [WORD_W-1:0]     shreg, shreg_n;
  logic [DATA_WIDTH-1:0] wr_data_n;
  logic [DIM-1:0]        fifo_a_wr_n;
  logic                  start_acc;

  // Read handshake: a request is accepted on a cycle with mem_read=1 and
  // mem_waitrequest=0; address and read stay frozen until then. Data returns
  // later as a single mem_readdatavalid beat, honoured only in READ_WAIT.
  always_comb begin
    state_n   = state;
    row_n     = row;
    cnt_n     = cnt;
    shreg_n   = shreg;
    wr_data_n = '0;
    start_acc = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_READ_REQ;
          row_n     = '0;
          cnt_n     = '0;
          start_acc = 1'b1;
        end
      end
      S_READ_REQ: begin
        if (!mem_waitrequest) state_n = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (mem_readdatavalid) begin
          state_n   = S_UNPACK;
          cnt_n     = '0;
          wr_data_n = mem_readdata[WORD_W-1 -: DATA_WIDTH];
          shreg_n   = mem_readdata << DATA_WIDTH;
        end
      end
      S_UNPACK: begin
        // Output bytes are registered, so byte k+1 is staged while byte k is visible.
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (row == ROW_B) begin
            state_n = S_COMPUTE;
          end else begin
            row_n   = row + ROW_W'(1);
            state_n = S_READ_REQ;
          end
        end else begin
          cnt_n     = cnt + CNT_W'(1);
          wr_data_n = shreg[WORD_W-1 -: DATA_WIDTH];
          shreg_n   = shreg << DATA_WIDTH;
        end
      end
      S_COMPUTE: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_a_wr_n = '0;
    for (int i = 0; i < DIM; i++) begin
      fifo_a_wr_n[i] = (state_n == S_UNPACK) && (row_n == ROW_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      row          <= '0;
      cnt          <= '0;
      shreg        <= '0;
      mem_address  <= '0;
      mem_read     <= 1'b0;
      fifo_a_wr    <= '0;
      fifo_b_wr    <= 1'b0;
      fifo_wr_data <= '0;
      fifo_rd_en   <= 1'b0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      row          <= row_n;
      cnt          <= cnt_n;
      shreg        <= shreg_n;
      mem_address  <= ADDR_WIDTH'(row_n);
      mem_read     <= (state_n == S_READ_REQ);
      fifo_a_wr    <= fifo_a_wr_n;
      fifo_b_wr    <= (state_n == S_UNPACK) && (row_n == ROW_B);
      fifo_wr_data <= wr_data_n;
      fifo_rd_en   <= (state_n == S_COMPUTE);
      mac_en       <= fifo_rd_en;
      mac_clr      <= start_acc;
      busy         <= (state_n != S_IDLE) && (state_n != S_DONE);
      done         <= (state_n == S_DONE);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Randomised bench for mac_array_sequencer: a cycle-stepped memory slave plus a
// scoreboard of expected FIFO writes and a done-cycle model from the timing rules.
module tb_mac_array_sequencer;
  localparam int DIM = 8;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int WW  = DIM * DW;
  localparam logic [2:0] IDLE_CODE = 3'd0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_read, fifo_b_wr, fifo_rd_en, mac_en, mac_clr;
  logic [AW-1:0] mem_address;
  logic          mem_waitrequest = 1'b0;
  logic [WW-1:0] mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic [DIM-1:0] fifo_a_wr;
  logic [DW-1:0] fifo_wr_data;
  logic [2:0]    state_dbg;

  mac_array_sequencer #(.DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .fifo_a_wr(fifo_a_wr),
    .fifo_b_wr(fifo_b_wr), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .mac_en(mac_en), .mac_clr(mac_clr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WW-1:0] mem_img [0:DIM];
  int            lat_cfg [0:DIM];
  int            stall_cfg [0:DIM];
  logic [11:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_fifo_a_wr"}, fifo_a_wr, 0);
    check({tag, "_fifo_b_wr"}, fifo_b_wr, 0);
    check({tag, "_fifo_wr_data"}, fifo_wr_data, 0);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_mac_en"}, mac_en, 0);
    check({tag, "_mac_clr"}, mac_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, IDLE_CODE);
  endtask

  task automatic fill_directed();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        mem_img[i][WW-1-DW*j -: DW] = DW'(DIM * i + j + 1);
    for (int j = 0; j < DIM; j++) mem_img[DIM][WW-1-DW*j -: DW] = DW'(j + 1);
  endtask

  task automatic set_timing(input int stall, input int lat);
    for (int r = 0; r <= DIM; r++) begin
      stall_cfg[r] = stall;
      lat_cfg[r]   = lat;
    end
  endtask

  // Start-to-done: 100 cycles at zero wait, +1 per stall cycle, +1 per extra latency cycle.
  function automatic int exp_done_cycle();
    int t;
    t = 100;
    for (int r = 0; r <= DIM; r++) t += stall_cfg[r] + lat_cfg[r] - 1;
    return t;
  endfunction

  task automatic run_one(input int exp_done, input bit start_in_compute,
                         input bit stray, input int abort_row);
    int cycle, stall_left, valid_at, req_row, data_row, rows_back;
    int a_wr, b_wr, rd_n, mac_n, clr_n, done_at;
    bit prev_rd, extra_sent, stray_sent;
    logic [11:0] e;
    logic [3:0]  r;

    exp_q.delete();
    for (int rr = 0; rr <= DIM; rr++)
      for (int j = 0; j < DIM; j++)
        exp_q.push_back({4'(rr), mem_img[rr][WW-1-DW*j -: DW]});

    stall_left = stall_cfg[0];
    valid_at = -1; req_row = 0; data_row = 0; rows_back = 0;
    a_wr = 0; b_wr = 0; rd_n = 0; mac_n = 0; clr_n = 0; done_at = -1;
    prev_rd = 1'b0; extra_sent = 1'b0; stray_sent = 1'b0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycle = 1;
    while (cycle < 400) begin
      if (cycle == 1) begin
        check("busy_first", busy, 1);
        check("done_cleared", done, 0);
        check("addr_first", mem_address, 0);
        check("clr_first", mac_clr, 1);
      end
      if (mac_clr) clr_n++;
      if (done) begin
        done_at = cycle;
        break;
      end

      if (fifo_a_wr != '0 || fifo_b_wr) begin
        check("wr_onehot", $countones({fifo_a_wr, fifo_b_wr}), 1);
        r = 4'(DIM);
        for (int i = 0; i < DIM; i++) if (fifo_a_wr[i]) r = 4'(i);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check("wr_row_byte", {r, fifo_wr_data}, e);
        check("wr_after_valid", (int'(r) < rows_back), 1);
        if (fifo_b_wr) b_wr++; else a_wr++;
      end
      if (fifo_rd_en) rd_n++;
      if (mac_en) mac_n++;
      check("mac_en_lag", mac_en, prev_rd);
      prev_rd = fifo_rd_en;

      // Memory slave: data beat, optional stray beat, then request/stall handling.
      mem_readdatavalid = 1'b0;
      if (cycle == valid_at) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = mem_img[data_row];
        rows_back++;
      end else if (stray && !stray_sent && fifo_a_wr != '0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = {$urandom, $urandom};
        stray_sent = 1'b1;
      end
      if (mem_read) begin
        check("req_addr", mem_address, req_row);
        if (stall_left > 0) begin
          mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          mem_waitrequest = 1'b0;
          valid_at = cycle + ((req_row <= DIM) ? lat_cfg[req_row] : 1);
          data_row = (req_row <= DIM) ? req_row : DIM;
          req_row++;
          stall_left = (req_row <= DIM) ? stall_cfg[req_row] : 0;
        end
      end else begin
        mem_waitrequest = 1'b0;
      end

      start = 1'b0;
      if (start_in_compute && fifo_rd_en && !extra_sent) begin
        start = 1'b1;
        extra_sent = 1'b1;
      end

      if (abort_row >= 0 && fifo_a_wr[abort_row]) begin
        rst_n = 1'b0;
        break;
      end
      @(negedge clk);
      cycle++;
    end
    start = 1'b0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    if (abort_row < 0) begin
      if (done_at < 0) $display("FAIL run_timeout: done never seen within %0d cycles", cycle);
      check("done_cycle", done_at, exp_done);
      check("a_writes", a_wr, DIM * DIM);
      check("b_writes", b_wr, DIM);
      check("rd_en_cycles", rd_n, DIM);
      check("mac_en_cycles", mac_n, DIM);
      check("clr_pulses", clr_n, 1);
      check("writes_left", exp_q.size(), 0);
      check("stray_used", stray_sent, stray);
      check("extra_start_used", extra_sent, start_in_compute);
    end
  endtask

  task automatic check_done_held();
    @(negedge clk);
    check("done_held", done, 1);
    check("busy_in_done", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Zero-wait directed run from IDLE.
    fill_directed();
    set_timing(0, 1);
    run_one(exp_done_cycle(), 1'b0, 1'b0, -1);
    check_done_held();

    // Three stall cycles on row 4, started from DONE.
    stall_cfg[4] = 3;
    check("stall_model", exp_done_cycle(), 103);
    run_one(exp_done_cycle(), 1'b0, 1'b0, -1);
    check_done_held();

    // Slow data plus a stray valid beat during UNPACK.
    set_timing(0, 5);
    run_one(exp_done_cycle(), 1'b0, 1'b1, -1);
    check_done_held();

    // Extra start during COMPUTE must not disturb timing.
    set_timing(0, 1);
    run_one(exp_done_cycle(), 1'b1, 1'b0, -1);
    check_done_held();

    // Reset during UNPACK of row 3, then a clean run.
    run_one(0, 1'b0, 1'b0, 3);
    @(negedge clk);
    check_idle("midrst");
    rst_n = 1'b1;
    run_one(exp_done_cycle(), 1'b0, 1'b0, -1);
    check_done_held();

    // Random contents, stalls and latencies.
    for (int k = 0; k < 4; k++) begin
      for (int rr = 0; rr <= DIM; rr++) begin
        mem_img[rr]   = {$urandom, $urandom};
        stall_cfg[rr] = $urandom_range(0, 2);
        lat_cfg[rr]   = $urandom_range(1, 3);
      end
      run_one(exp_done_cycle(), k[0], k[1], -1);
      check_done_held();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
